// File: rtl/pwl_run_sequencer.sv
// Run controller for the piecewise-linear chaotic oscillator datapath.
// Loads initial conditions, paces one state-register enable per StepCycles
// clocks for N iterations, decimates the x/y/z trajectory onto a one-entry
// valid/ready buffer (stalling the datapath on back-pressure) and pulses
// done at the end of the run.
module pwl_run_sequencer #(
   parameter int Width      = 16,
   parameter int CntWidth   = 20,
   parameter int DecWidth   = 8,
   parameter int StepCycles = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [CntWidth-1:0] n_iter_i,
   input  logic [DecWidth-1:0] decim_i,
   input  logic [Width-1:0]    xn_i,
   input  logic [Width-1:0]    yn_i,
   input  logic [Width-1:0]    zn_i,
   output logic                load_o,
   output logic                step_en_o,
   output logic [Width-1:0]    x_o,
   output logic [Width-1:0]    y_o,
   output logic [Width-1:0]    z_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [CntWidth-1:0] iter_o,
   output logic                busy_o,
   output logic                done_o
);

   // Phase counter needs at least one bit even when StepCycles is 1.
   localparam int PhW = (StepCycles > 1) ? $clog2(StepCycles) : 1;
   localparam logic [PhW-1:0] PhLast = PhW'(StepCycles - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CntWidth-1:0] n_q, n_d;
   logic [DecWidth-1:0] dec_max_q, dec_max_d;   // D-1, with D=0 folded to D=1
   logic [DecWidth-1:0] dec_q, dec_d;           // k mod D for the next step
   logic [CntWidth-1:0] iter_q, iter_d;
   logic [PhW-1:0]      phase_q, phase_d;
   logic                valid_q, valid_d;
   logic [Width-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
   logic                load_q, load_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic handshake;
   logic commit_slot;
   logic emit_step;
   logic stall;
   logic commit;
   logic capture;

   // Step qualification: the enable must react to ready_i in the same commit
   // cycle (same-cycle free / stall), so it is decoded from registered state
   // plus ready_i rather than registered itself.
   always_comb begin
      handshake   = valid_q & ready_i;
      commit_slot = (state_q == S_COMPUTE) && (phase_q == PhLast) && !abort_i;
      emit_step   = (dec_q == '0);
      stall       = emit_step & valid_q & ~ready_i;
      commit      = commit_slot & ~stall;
      capture     = commit & emit_step;
   end

   assign step_en_o = commit;

   // Next-state and datapath-register decode for the run FSM.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      dec_max_d = dec_max_q;
      dec_d     = dec_q;
      iter_d    = iter_q;
      phase_d   = phase_q;
      valid_d   = valid_q;
      x_d       = x_q;
      y_d       = y_q;
      z_d       = z_q;

      // A handshake always empties the buffer; a capture below may refill it.
      if (handshake) begin
         valid_d = 1'b0;
      end

      if (abort_i) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  n_d       = n_iter_i;
                  dec_max_d = (decim_i == '0) ? '0 : (decim_i - DecWidth'(1));
                  dec_d     = '0;
                  iter_d    = '0;
                  phase_d   = '0;
                  state_d   = S_LOAD;
               end
            end
            S_LOAD: begin
               state_d = (n_q != '0) ? S_COMPUTE : S_DRAIN;
            end
            S_COMPUTE: begin
               if (commit) begin
                  iter_d  = iter_q + CntWidth'(1);
                  phase_d = '0;
                  dec_d   = (dec_q == dec_max_q) ? '0 : (dec_q + DecWidth'(1));
                  if ((iter_q + CntWidth'(1)) == n_q) begin
                     state_d = S_DRAIN;
                  end
               end else if (phase_q != PhLast) begin
                  phase_d = phase_q + PhW'(1);
               end
               // Capture the pre-update state k on an emit step.
               if (capture) begin
                  x_d     = xn_i;
                  y_d     = yn_i;
                  z_d     = zn_i;
                  valid_d = 1'b1;
               end
            end
            S_DRAIN: begin
               if (!valid_q || ready_i) begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      load_d = (state_d == S_LOAD);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers, cleared asynchronously by rst_i.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         dec_max_q <= '0;
         dec_q     <= '0;
         iter_q    <= '0;
         phase_q   <= '0;
         valid_q   <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         load_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         dec_max_q <= dec_max_d;
         dec_q     <= dec_d;
         iter_q    <= iter_d;
         phase_q   <= phase_d;
         valid_q   <= valid_d;
         x_q       <= x_d;
         y_q       <= y_d;
         z_q       <= z_d;
         load_q    <= load_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign load_o  = load_q;
   assign valid_o = valid_q;
   assign x_o     = x_q;
   assign y_o     = y_q;
   assign z_o     = z_q;
   assign iter_o  = iter_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_pwl_run_sequencer.sv
// Bench for pwl_run_sequencer: table of runs applied through a run task
// plus directed abort, abort-with-start and asynchronous reset sequences.
module tb_pwl_run_sequencer;

   localparam int Width      = 16;
   localparam int CntWidth   = 20;
   localparam int DecWidth   = 8;
   localparam int StepCycles = 2;

   logic                clk = 1'b0;
   logic                rst_i = 1'b1;
   logic                start_i = 1'b0;
   logic                abort_i = 1'b0;
   logic [CntWidth-1:0] n_iter_i = '0;
   logic [DecWidth-1:0] decim_i = '0;
   logic [Width-1:0]    xn, yn, zn;
   logic                load_o, step_en_o, valid_o, busy_o, done_o;
   logic                ready_i = 1'b1;
   logic [Width-1:0]    x_o, y_o, z_o;
   logic [CntWidth-1:0] iter_o;

   int checks = 0;
   int failures = 0;

   pwl_run_sequencer #(
      .Width      (Width),
      .CntWidth   (CntWidth),
      .DecWidth   (DecWidth),
      .StepCycles (StepCycles)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .abort_i   (abort_i),
      .n_iter_i  (n_iter_i),
      .decim_i   (decim_i),
      .xn_i      (xn),
      .yn_i      (yn),
      .zn_i      (zn),
      .load_o    (load_o),
      .step_en_o (step_en_o),
      .x_o       (x_o),
      .y_o       (y_o),
      .z_o       (z_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .iter_o    (iter_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   always #5 clk = ~clk;

   // Toy datapath: x counts up, y by 3, z counts down; load clears all.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         xn <= '0;
         yn <= '0;
         zn <= '0;
      end else if (load_o) begin
         xn <= '0;
         yn <= '0;
         zn <= '0;
      end else if (step_en_o) begin
         xn <= xn + 16'd1;
         yn <= yn + 16'd3;
         zn <= zn - 16'd1;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [CntWidth-1:0] n;
      logic [DecWidth-1:0] d;
      int                  stall_len;
      int                  exp_samples;
      int                  exp_last;
   } vec_t;

   // Apply one run: start pulse, then watch every cycle until done_o.
   task automatic run_vec(input vec_t v);
      int          samples = 0;
      int          steps = 0;
      int          loads = 0;
      int          first_valid = -1;
      int          last_step = -1;
      int          last_hs = -1;
      int          last_x = -1;
      bit          done_seen = 0;
      bit          held = 0;
      logic [15:0] held_x = '0;
      logic [15:0] ez;
      int          deff;
      deff = (v.d == 0) ? 1 : int'(v.d);
      n_iter_i = v.n;
      decim_i  = v.d;
      ready_i  = 1'b1;
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         if (valid_o && first_valid < 0) first_valid = cyc;
         ready_i = !(v.stall_len > 0 && first_valid >= 0 && (cyc - first_valid) < v.stall_len);
         // Mid-run start pulse and new settings must be ignored.
         if (cyc == 4) begin
            start_i  = 1'b1;
            n_iter_i = v.n + 20'd3;
            decim_i  = 8'd2;
         end else begin
            start_i = 1'b0;
         end
         #1;
         if (load_o) begin
            loads++;
            check("load_cycle", cyc, 1);
         end
         if (step_en_o) begin
            steps++;
            last_step = cyc;
            if (v.stall_len == 0)
               check("step_cycle", cyc, StepCycles + 1 + StepCycles * (steps - 1));
         end
         if (deff == 1)
            check("no_step_when_full", step_en_o & valid_o & ~ready_i, 0);
         if (valid_o && held)
            check("x_stable", x_o, held_x);
         if (valid_o && ready_i) begin
            ez = 16'd0 - 16'(samples * deff);
            check("x_sample", x_o, samples * deff);
            check("y_sample", y_o, 3 * samples * deff);
            check("z_sample", z_o, ez);
            last_x = int'(x_o);
            last_hs = cyc;
            samples++;
            held = 0;
         end else if (valid_o) begin
            held   = 1;
            held_x = x_o;
         end
         if (done_o) begin
            done_seen = 1;
            check("done_busy", busy_o, 1);
            check("done_iter", iter_o, v.n);
            check("done_cycle", cyc, (v.n == 0) ? 3 : last_step + 2);
            if (deff == 1 && v.n != 0) check("done_after_hs", cyc, last_hs + 1);
            break;
         end
         @(negedge clk);
      end
      start_i = 1'b0;
      ready_i = 1'b1;
      if (!done_seen) check("run_timeout", 0, 1);
      check("sample_count", samples, v.exp_samples);
      check("step_count", steps, v.n);
      check("load_count", loads, 1);
      if (v.exp_samples > 0) check("last_sample", last_x, v.exp_last);
      @(negedge clk);
      #1;
      check("idle_busy", busy_o, 0);
      check("idle_done", done_o, 0);
      $display("run n=%0d d=%0d stall=%0d samples=%0d steps=%0d", v.n, v.d, v.stall_len, samples, steps);
   endtask

   vec_t vecs[6];
   int   steps_seen;

   initial begin
      vecs[0] = '{n: 20'd5,  d: 8'd1, stall_len: 0, exp_samples: 5,  exp_last: 4};
      vecs[1] = '{n: 20'd10, d: 8'd4, stall_len: 0, exp_samples: 3,  exp_last: 8};
      vecs[2] = '{n: 20'd10, d: 8'd0, stall_len: 0, exp_samples: 10, exp_last: 9};
      vecs[3] = '{n: 20'd4,  d: 8'd1, stall_len: 7, exp_samples: 4,  exp_last: 3};
      vecs[4] = '{n: 20'd0,  d: 8'd1, stall_len: 0, exp_samples: 0,  exp_last: 0};
      vecs[5] = '{n: 20'd7,  d: 8'd3, stall_len: 0, exp_samples: 3,  exp_last: 6};

      // Reset state, observed while rst_i is still high.
      #3;
      check("rst_load", load_o, 0);
      check("rst_step", step_en_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_iter", iter_o, 0);
      check("rst_x", x_o, 0);
      @(negedge clk);
      rst_i = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Abort after 10 committed steps of a 100-iteration run.
      n_iter_i = 20'd100;
      decim_i  = 8'd1;
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      steps_seen = 0;
      for (int c = 0; c < 200 && steps_seen < 10; c++) begin
         #1;
         if (step_en_o) steps_seen++;
         @(negedge clk);
      end
      check("abort_setup_steps", steps_seen, 10);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      #1;
      check("abort_busy", busy_o, 0);
      check("abort_valid", valid_o, 0);
      check("abort_iter", iter_o, 10);
      check("abort_load", load_o, 0);
      check("abort_done", done_o, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         check("abort_no_done", done_o, 0);
         check("abort_stay_idle", busy_o, 0);
      end
      $display("abort after %0d steps, iter=%0d", steps_seen, iter_o);
      run_vec(vecs[0]);

      // Abort together with start in IDLE: abort wins.
      @(negedge clk);
      start_i = 1'b1;
      abort_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      #1;
      check("abort_start_busy", busy_o, 0);
      check("abort_start_load", load_o, 0);
      $display("abort+start in idle busy=%0d", busy_o);

      // Asynchronous reset between clock edges in the middle of COMPUTE.
      n_iter_i = 20'd20;
      decim_i  = 8'd1;
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      check("pre_rst_busy", busy_o, 1);
      #1;
      rst_i   = 1'b1;
      start_i = 1'b1;
      #1;
      check("arst_busy", busy_o, 0);
      check("arst_valid", valid_o, 0);
      check("arst_iter", iter_o, 0);
      check("arst_step", step_en_o, 0);
      check("arst_x", x_o, 0);
      @(negedge clk);
      #1;
      check("arst_start_ignored", busy_o, 0);
      check("arst_load", load_o, 0);
      @(negedge clk);
      start_i = 1'b0;
      rst_i   = 1'b0;
      $display("async reset mid-run busy=%0d iter=%0d", busy_o, iter_o);
      run_vec(vecs[5]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
